// File: rtl/lfsr_misr_gen.sv
// rtl/lfsr_misr_gen.sv - XNOR-feedback LFSR / MISR with programmed run length
// Optional lock-up recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_misr_gen #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(16'hD008),
  parameter int                 LEN   = 65535
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             EN,
  input  logic             MODE,
  input  logic [WIDTH-1:0] SEED,
  input  logic [WIDTH-1:0] DI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             LOCKUP
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] LEN_M1 = WIDTH'(LEN - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state;
  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;

  // XNOR form: inverted parity of the tapped stages
  assign fb      = ~^(Q & TAPS);
  assign shifted = {Q[WIDTH-2:0], fb};
  assign q_next  = MODE ? (shifted ^ DI) : shifted;

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup_q;
  assign LOCKUP = lockup_q;
`else
  assign LOCKUP = 1'b0;
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= S_IDLE;
      Q     <= '0;
      CNT   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_q <= 1'b0;
`endif
    end else if (START) begin
      // START wins over EN in every state, including a restart mid-run
      state <= S_RUN;
      Q     <= SEED;
      CNT   <= '0;
      BUSY  <= 1'b1;
      DONE  <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          if (EN) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (!MODE && (&Q)) begin
              Q        <= '0;
              lockup_q <= 1'b1;
            end else begin
              Q <= q_next;
            end
`else
            Q <= q_next;
`endif
            CNT <= CNT + ONE;
            if (CNT == LEN_M1) begin
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
